// File: rtl/hough_vote_if.sv
// hough_vote_if: feature-point stream and frame markers from the lane ROI extractor
interface hough_vote_if;
    logic        frame_start;
    logic        frame_end;
    logic        feature_de;
    logic [11:0] x_left;
    logic [11:0] y_left;
    logic [11:0] x_right;
    logic [11:0] y_right;
    modport master (output frame_start, frame_end, feature_de, x_left, y_left, x_right, y_right);
    modport slave  (input  frame_start, frame_end, feature_de, x_left, y_left, x_right, y_right);
endinterface

// File: rtl/hough_vote.sv
// hough_vote: buffers lane feature points, casts per-angle Hough votes and reports the strongest line per side
module hough_vote #(
    parameter int H_DISP     = 640,
    parameter int V_DISP     = 480,
    parameter int THETA_NUM  = 16,
    parameter int RHO_W      = 9,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    hough_vote_if.slave                  fin,
    output logic [$clog2(THETA_NUM)-1:0] trig_addr,
    input  logic signed [11:0]           trig_cos,
    input  logic signed [11:0]           trig_sin,
    output logic                         busy,
    output logic                         fifo_ovf,
    output logic                         line_valid,
    output logic [$clog2(THETA_NUM)-1:0] left_theta,
    output logic [RHO_W-1:0]             left_rho,
    output logic [CNT_W-1:0]             left_votes,
    output logic [$clog2(THETA_NUM)-1:0] right_theta,
    output logic [RHO_W-1:0]             right_rho,
    output logic [CNT_W-1:0]             right_votes
);
    localparam int TW = $clog2(THETA_NUM);
    localparam int XW = $clog2(H_DISP);
    localparam int YW = $clog2(V_DISP);
    localparam int AW = 1 + TW + RHO_W;
    localparam int FA = $clog2(FIFO_DEPTH);
    localparam int FW = FA + 1;
    localparam int PW = 1 + XW + YW;
    localparam int HALF = 2 ** (RHO_W - 1);
    localparam int BIN_MAX = 2 ** RHO_W - 1;
    localparam logic [AW-1:0] LAST = '1;
    localparam logic [TW-1:0] ANG_LAST = TW'(THETA_NUM - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, VOTE, SEARCH, DONE} state_t;
    state_t state, state_d;

    logic [AW-1:0] cnt;
    logic end_l, drained;
    logic [PW-1:0] fifo_mem [FIFO_DEPTH];
    logic [FW-1:0] wp, rp;
    logic push, pop, full, empty;
    logic [PW-1:0] pin, pout;
    logic s0_v, s1_v, s2_v, s3_v;
    logic s0_side, s1_side;
    logic [XW-1:0] s0_px, s1_px;
    logic [YW-1:0] s0_py, s1_py;
    logic [TW-1:0] s1_theta;
    logic signed [24:0] s1_sum, s1_q;
    logic [RHO_W-1:0] s1_bin;
    logic [AW-1:0] s2_addr, s3_addr;
    logic s3_fwd;
    logic [CNT_W-1:0] s3_fwd_val, s3_cur, s3_wd;
    logic [CNT_W-1:0] acc [2**AW];
    logic [CNT_W-1:0] rd, wd;
    logic [AW-1:0] ra, wa;
    logic we;
    logic srch_v;
    logic [AW-1:0] srch_addr;
    logic [CNT_W-1:0] bl_v, br_v, nl_v, nr_v;
    logic [AW-2:0] bl_a, br_a, nl_a, nr_a;

    // coordinates never exceed the image, so the FIFO keeps only the in-image bits
    assign pin = {fin.x_left == '0, XW'(fin.x_left | fin.x_right), YW'(fin.y_left | fin.y_right)};
    assign pout = fifo_mem[rp[FA-1:0]];
    assign empty = wp == rp;
    assign full = (wp[FA] != rp[FA]) && (wp[FA-1:0] == rp[FA-1:0]);
    assign push = fin.feature_de && !fin.frame_start;
    assign pop = state == VOTE && !empty && (!s0_v || trig_addr == ANG_LAST);
    assign drained = end_l && empty && !s0_v && !s1_v && !s2_v && !s3_v;
    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_d;

    always_comb begin
        state_d = fin.frame_start               ? CLEAR  :
                  state == IDLE                 ? IDLE   :
                  state == CLEAR  && cnt == LAST ? VOTE   :
                  state == VOTE   && drained     ? SEARCH :
                  state == SEARCH && cnt == LAST ? DONE   :
                  state == DONE                 ? IDLE   : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            end_l <= 1'b0;
            wp <= '0;
            rp <= '0;
            fifo_ovf <= 1'b0;
            trig_addr <= '0;
            {s0_v, s1_v, s2_v, s3_v} <= '0;
            line_valid <= 1'b0;
            {left_theta, left_rho, left_votes} <= '0;
            {right_theta, right_rho, right_votes} <= '0;
        end else begin
            cnt <= (fin.frame_start || state_d != state) ? '0 : cnt + 1'b1;
            end_l <= fin.frame_start ? 1'b0 : end_l || fin.frame_end;
            fifo_ovf <= fin.frame_start ? 1'b0 : fifo_ovf || (push && full);
            wp <= fin.frame_start ? '0 : wp + FW'(push && !full);
            rp <= fin.frame_start ? '0 : rp + FW'(pop);
            s0_v <= !fin.frame_start && (pop || (s0_v && trig_addr != ANG_LAST));
            trig_addr <= (!fin.frame_start && s0_v && trig_addr != ANG_LAST) ? trig_addr + 1'b1 : '0;
            s1_v <= s0_v && !fin.frame_start;
            s2_v <= s1_v && !fin.frame_start;
            s3_v <= s2_v && !fin.frame_start;
            line_valid <= state == DONE && !fin.frame_start;
            if (state == DONE && !fin.frame_start) begin
                {left_theta, left_rho} <= nl_a;
                left_votes <= nl_v;
                {right_theta, right_rho} <= nr_a;
                right_votes <= nr_v;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) fifo_mem[wp[FA-1:0]] <= pin;
        if (pop) {s0_side, s0_px, s0_py} <= pout;
        {s1_side, s1_px, s1_py, s1_theta} <= {s0_side, s0_px, s0_py, trig_addr};
        s2_addr <= {s1_side, s1_theta, s1_bin};
        s3_addr <= s2_addr;
        s3_fwd <= s3_v && s3_addr == s2_addr;
        s3_fwd_val <= s3_wd;
        srch_v <= state == SEARCH;
        srch_addr <= cnt;
        {bl_v, bl_a, br_v, br_a} <= state == SEARCH ? {nl_v, nl_a, nr_v, nr_a} : '0;
    end

    always_comb begin
        s1_sum = 25'($signed({1'b0, s1_px})) * 25'(trig_cos) + 25'($signed({1'b0, s1_py})) * 25'(trig_sin);
        s1_q = ((s1_sum >>> 10) >>> 2) + 25'(HALF);
        s1_bin = s1_q < 0 ? '0 : s1_q > 25'(BIN_MAX) ? '1 : s1_q[RHO_W-1:0];
    end

    // a read racing the write to the same bin takes the value being written
    assign s3_cur = s3_fwd ? s3_fwd_val : rd;
    assign s3_wd = &s3_cur ? s3_cur : s3_cur + 1'b1;

    assign we = state == CLEAR || s3_v;
    assign wa = state == CLEAR ? cnt : s3_addr;
    assign wd = state == CLEAR ? '0 : s3_wd;
    assign ra = state == SEARCH ? cnt : s2_addr;

    always_ff @(posedge clk) begin
        if (we) acc[wa] <= wd;
        rd <= acc[ra];
    end

    always_comb begin
        {nl_v, nl_a, nr_v, nr_a} = {bl_v, bl_a, br_v, br_a};
        if (srch_v && !srch_addr[AW-1] && rd > bl_v) {nl_v, nl_a} = {rd, srch_addr[AW-2:0]};
        if (srch_v && srch_addr[AW-1] && rd > br_v) {nr_v, nr_a} = {rd, srch_addr[AW-2:0]};
    end
endmodule

// File: doc/hough_vote.md
Name: hough_vote

Overview:
- Consumer of the feature-point stream from the lane ROI extractor.
- Buffers incoming left/right feature points in a small FIFO and casts Hough votes: one vote per point per angle, into separate left and right accumulators.
- At end of frame, scans both accumulators and reports the strongest (theta, rho) line per side to the lane overlay stage.

Parameters:
- H_DISP, 640: image width.
- V_DISP, 480: image height.
- THETA_NUM, 16: angle count; theta_k = k*180/THETA_NUM degrees; must be a power of 2.
- RHO_W, 9: rho bin index width (512 bins).
- CNT_W, 8: vote counter width.
- FIFO_DEPTH, 16: point FIFO depth; must be a power of 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- frame_start  in  1  one-cycle pulse; clears accumulators and begins a new frame
- frame_end  in  1  one-cycle pulse; last feature point of the frame has been delivered
- x_left  in  12  left feature x; 0 when the point is not a left point
- y_left  in  12  left feature y
- x_right  in  12  right feature x; 0 when the point is not a right point
- y_right  in  12  right feature y
- feature_de  in  1  feature point valid
- trig_addr  out  log2(THETA_NUM)  angle index to the external cos/sin ROM
- trig_cos  in  12  signed Q1.10 cos(theta), valid 1 clk after trig_addr
- trig_sin  in  12  signed Q1.10 sin(theta), valid 1 clk after trig_addr
- busy  out  1  high in any state other than IDLE
- fifo_ovf  out  1  sticky: a point was dropped because the FIFO was full
- line_valid  out  1  one-cycle pulse; result outputs updated
- left_theta  out  log2(THETA_NUM)  angle index of the left peak
- left_rho  out  RHO_W  rho bin of the left peak
- left_votes  out  CNT_W  vote count of the left peak
- right_theta  out  log2(THETA_NUM)  angle index of the right peak
- right_rho  out  RHO_W  rho bin of the right peak
- right_votes  out  CNT_W  vote count of the right peak

Behaviour:
- Reset (asynchronous, rst=1):
  - All outputs 0; FSM in IDLE; FIFO empty.
  - Accumulator contents undefined until the next CLEAR.
- Point capture:
  - On feature_de=1: side = left if x_left!=0, else right; px = x_left|x_right, py = y_left|y_right.
  - Push {side, px, py} into the FIFO in the same cycle.
  - Push when full: point dropped, fifo_ovf set to 1. fifo_ovf clears only on frame_start.
  - Push and pop in the same cycle are legal when the FIFO is neither empty nor full.
- FSM:
  - IDLE: frame_start -> CLEAR.
  - CLEAR:
    - Writes 0 to every accumulator address {side, theta, rho_bin}, one address per clk: 2*THETA_NUM*2^RHO_W cycles.
    - The FIFO keeps accepting points during CLEAR.
    - Exits to VOTE.
  - VOTE:
    - While the FIFO is non-empty: pop a point and sweep trig_addr = 0..THETA_NUM-1, one angle per clk.
    - The next point may follow back-to-back.
    - frame_end is latched whenever it occurs.
    - Once the end is latched, the FIFO is empty and the pipeline has drained -> SEARCH.
  - SEARCH:
    - Reads all addresses sequentially, one per clk, in address order.
    - Per side, tracks the maximum with a strict greater-than compare, so ties keep the lowest address.
    - Then -> DONE.
  - DONE: load all result outputs, pulse line_valid for 1 clk, -> IDLE. Results hold until the next DONE.
  - frame_start in any state other than IDLE: discard FIFO contents, clear fifo_ovf, restart CLEAR. Results are not updated.
  - frame_start in the same cycle as feature_de: the point is discarded.
- Vote pipeline (stages per angle):
  - S0: issue trig_addr.
  - S1:
    - rho = (px*trig_cos + py*trig_sin) >>> 10, signed 25-bit intermediate.
    - bin = (rho >>> 2) + 2^(RHO_W-1), saturated to the range 0..2^RHO_W-1.
  - S2: read accumulator.
  - S3: write count+1, saturating at 2^CNT_W-1.
- RAW hazard: an S2 read whose address matches the S3 write forwards the S3 write value.
- Accumulator is single-clock inferred RAM with one read port and one write port.
- If both sides have 0 votes: that side's theta, rho and votes report 0.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst mid-VOTE.
  - Required: busy=0, line_valid=0, all results 0, fifo_ovf=0; the next frame_start runs CLEAR for 16384 cycles.
- Single left point:
  - Stimulus: frame_start, point (100,300) left, frame_end.
  - ROM model: round(1024*cos) / round(1024*sin).
  - Required: left_theta=0, left_rho=281, left_votes=1; right_votes=0, right_theta=0, right_rho=0.
- Collinear pair:
  - Stimulus: left points (100,300), (100,350).
  - Required: left_theta=0, left_rho=281, left_votes=2.
- Both sides:
  - Stimulus: right point (500,300) plus the left point (100,300).
  - Required: right_theta=0, right_rho=381, right_votes=1; left result as in the single-point case.
- Overflow:
  - Stimulus: 40 back-to-back feature_de points during CLEAR.
  - Required: fifo_ovf=1, exactly 16 points voted; fifo_ovf=0 after the next frame_start.
- Restart:
  - Stimulus: frame_start during SEARCH.
  - Required: no line_valid for the aborted frame; the new frame completes normally.
- Saturation:
  - Stimulus: the same point pushed 300 times.
  - Required: left_votes=255.
